// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the system PLL out of reset and gates the downstream system reset
// on a stable lock. Runs entirely on the free-running reference clock so it
// keeps working when the PLL output clocks stop.
//
// Sequence: PLL_RESET (pulse pll_rst) -> WAIT_LOCK -> STABILIZE (lock must be
// held for LOCK_STABLE_CYCLES) -> RUN (sys_rst released). A lock attempt that
// overruns LOCK_TIMEOUT_CYCLES is retried up to MAX_RETRIES times before the
// block parks in FAIL. Lock losses seen in RUN are counted (saturating).
//
// Ports
//   refclk         in   reference clock, sole clock
//   rst            in   asynchronous active-high reset
//   pll_locked     in   PLL lock indication, asynchronous to refclk
//   restart        in   synchronous 1-cycle pulse, restarts from any state
//   pll_rst        out  active-high reset to the PLL
//   sys_rst        out  active-high reset to downstream logic
//   ready          out  high while in RUN
//   fail           out  high while parked in FAIL
//   lock_loss_cnt  out  saturating count of lock losses seen in RUN
//   state_dbg      out  current state encoding
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int RST_W   = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    // ------------------------------------------------------------------
    // pll_locked synchronizer; the FSM only ever looks at lk
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    state_t               state,     state_nxt;
    logic [RST_W-1:0]     rst_cnt,   rst_cnt_nxt;
    logic [CNT_W-1:0]     tmo_cnt,   tmo_cnt_nxt;
    logic [CNT_W-1:0]     stb_cnt,   stb_cnt_nxt;
    logic [RETRY_W-1:0]   retry_cnt, retry_cnt_nxt;
    logic [7:0]           loss_nxt;
    logic                 lock_drop;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        stb_cnt_nxt   = stb_cnt;
        retry_cnt_nxt = retry_cnt;
        loss_nxt      = lock_loss_cnt;

        // A lock drop in RUN is counted even when restart wins the transition.
        lock_drop = (state == ST_RUN) && !lk;
        if (lock_drop && (lock_loss_cnt != 8'hFF)) begin
            loss_nxt = lock_loss_cnt + 8'd1;
        end

        if (restart) begin
            state_nxt     = ST_PLL_RESET;
            retry_cnt_nxt = '0;
            rst_cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_PLL_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state_nxt   = ST_WAIT_LOCK;
                        rst_cnt_nxt = '0;
                        tmo_cnt_nxt = '0;
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end

                ST_WAIT_LOCK, ST_STABILIZE: begin
                    // The timeout spans the whole attempt; a lock drop in
                    // STABILIZE does not restart it.
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt_nxt = retry_cnt + 1'b1;
                            state_nxt     = ST_PLL_RESET;
                            rst_cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_FAIL;
                        end
                    end else if (state == ST_WAIT_LOCK) begin
                        if (lk) begin
                            state_nxt   = ST_STABILIZE;
                            stb_cnt_nxt = '0;
                        end
                    end else if (lk) begin
                        if (stb_cnt == STB_LAST) begin
                            state_nxt = ST_RUN;
                        end else begin
                            stb_cnt_nxt = stb_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt   = ST_WAIT_LOCK;
                        stb_cnt_nxt = '0;
                    end
                end

                ST_RUN: begin
                    if (!lk) begin
                        state_nxt     = ST_PLL_RESET;
                        retry_cnt_nxt = '0;
                        rst_cnt_nxt   = '0;
                    end
                end

                ST_FAIL: begin
                    // Parked until restart or rst.
                end

                default: begin
                    state_nxt = ST_PLL_RESET;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge that enters the new state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= ST_PLL_RESET;
            rst_cnt       <= '0;
            tmo_cnt       <= '0;
            stb_cnt       <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nxt;
            rst_cnt       <= rst_cnt_nxt;
            tmo_cnt       <= tmo_cnt_nxt;
            stb_cnt       <= stb_cnt_nxt;
            retry_cnt     <= retry_cnt_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (state_nxt == ST_PLL_RESET) || (state_nxt == ST_FAIL);
            sys_rst       <= (state_nxt != ST_RUN);
            ready         <= (state_nxt == ST_RUN);
            fail          <= (state_nxt == ST_FAIL);
        end
    end

    assign state_dbg = state;

endmodule
